// File: rtl/fifo_pkg.sv
// Shared constants, width helpers and status-flag type for the parametrised FIFO.
package fifo_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultDepth = 16;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (count == depth) is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic ready;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; only pointers define what is valid.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle registered read.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned DEPTH    = DefaultDepth,  // power of two, >= 4
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    ready,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  // Pointers carry a wrap bit above the address bits.
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, underflow_q;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] mem_rdata;
  fifo_status_t      status;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    status              = '0;
    status.full         = (count_q == CNT_W'(DEPTH));
    status.ready        = (count_q != '0);
    status.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    status.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_acc = rd & status.ready;
  assign wr_acc = wr & (~status.full | rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + (ADDR_W + 1)'(1);
    if (rd_acc) rptr_d = rptr_q + (ADDR_W + 1)'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= wr & ~wr_acc;
      underflow_q <= rd & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; rd only acknowledges it.
  assign data_out = status.ready ? mem_rdata : '0;
  assign rd_valid = status.ready;
`else
  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) data_q <= mem_rdata;
    end
  end

  assign data_out = data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = status.full;
  assign ready        = status.ready;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

endmodule
